// File: rtl/ahb_ram_responder_pkg.sv
// Shared AHB-Lite encodings and helpers for the RAM responder.
package cvw;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    HSIZE_BYTE  = 3'd0,
    HSIZE_HALF  = 3'd1,
    HSIZE_WORD  = 3'd2,
    HSIZE_DWORD = 3'd3,
    HSIZE_4W    = 3'd4,
    HSIZE_8W    = 3'd5,
    HSIZE_16W   = 3'd6,
    HSIZE_32W   = 3'd7
  } hsize_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } ram_state_e;

  localparam int unsigned WAIT_CNT_W = 4;

  // True when the low address bits are not a multiple of the transfer size.
  function automatic logic misaligned(input logic [7:0] addr_lo, input logic [2:0] size);
    return |(addr_lo & 8'((9'd1 << size) - 9'd1));
  endfunction

endpackage

// File: rtl/ahb_ram_responder_array.sv
// Synchronous RAM with one read and one write port and per-byte write enables.
// A read of the word being written in the same cycle returns the old contents.
module ahb_ram_array #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned WORDS = 1024
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     we_i,
  input  logic [$clog2(WORDS)-1:0] waddr_i,
  input  logic [XLEN-1:0]          wdata_i,
  input  logic [XLEN/8-1:0]        wstrb_i,
  input  logic                     re_i,
  input  logic [$clog2(WORDS)-1:0] raddr_i,
  output logic [XLEN-1:0]          rdata_o
);
  localparam int unsigned STRB_W = XLEN / 8;

  logic [XLEN-1:0] mem_q [WORDS];
  logic [XLEN-1:0] rdata_q;

  // Contents survive reset; only the read register is cleared.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wstrb_i[b]) mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)     rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ahb_ram_responder.sv
// AHB-Lite subordinate serving a byte-writable local RAM with a fixed
// wait-state count, two-cycle ERROR response and read-after-write forwarding.
module ahb_ram_responder
  import cvw::*;
#(
  parameter int unsigned PA_BITS = 34,
  parameter int unsigned XLEN    = 64,
  parameter int unsigned WORDS   = 1024,
  parameter logic [63:0] BASE    = 64'h8000_0000,
  parameter int unsigned WAITS   = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               HSELRam,
  input  logic [PA_BITS-1:0] HADDR,
  input  logic               HWRITE,
  input  logic [2:0]         HSIZE,
  input  logic [2:0]         HBURST,
  input  logic [1:0]         HTRANS,
  input  logic               HREADY,
  input  logic [XLEN-1:0]    HWDATA,
  input  logic [XLEN/8-1:0]  HWSTRB,
  output logic [XLEN-1:0]    HRDATA,
  output logic               HREADYRam,
  output logic               HRESPRam
);
  localparam int unsigned STRB_W   = XLEN / 8;
  localparam int unsigned OFF_BITS = $clog2(STRB_W);
  localparam int unsigned IDX_W    = $clog2(WORDS);
  localparam logic [63:0] LIMIT    = BASE + 64'(WORDS * STRB_W);
  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'((WAITS > 0) ? WAITS - 1 : 0);

  ram_state_e            state_q, state_d;
  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0]      addr_q, addr_d;
  logic                  write_q, write_d;
  logic                  pend_wr_q, pend_wr_d;
  logic                  fwd_q, fwd_d;
  logic [XLEN-1:0]       fwd_data_q, fwd_data_d;
  logic [STRB_W-1:0]     fwd_strb_q, fwd_strb_d;
  logic                  hready_q, hready_d;
  logic                  hresp_q, hresp_d;

  logic [63:0]      haddr_ext_c;
  logic [IDX_W-1:0] idx_c;
  logic             err_c, accept_c, wr_done_c, rd_now_c, rd_late_c, ram_re_c, fwd_hit_c;
  logic [IDX_W-1:0] ram_raddr_c;
  logic [XLEN-1:0]  ram_rdata_c, hrdata_c;
  logic             unused_hburst;

  assign unused_hburst = ^HBURST;

  // Address-phase decode: BASE is aligned to the RAM size, so the index is a plain slice.
  assign haddr_ext_c = 64'(HADDR);
  assign idx_c       = HADDR[OFF_BITS +: IDX_W];
  assign err_c       = (haddr_ext_c < BASE) || (haddr_ext_c >= LIMIT) ||
                       (HSIZE > 3'(OFF_BITS)) || misaligned(HADDR[7:0], HSIZE);
  assign accept_c    = HSELRam && HREADY &&
                       ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ)) &&
                       ((state_q == ST_IDLE) || (state_q == ST_ERR2));

  // A pending write always completes in the IDLE cycle that follows its address phase/waits.
  assign wr_done_c   = (state_q == ST_IDLE) && pend_wr_q;
  assign rd_now_c    = (WAITS == 0) && accept_c && !err_c && !HWRITE;
  assign rd_late_c   = (state_q == ST_WAIT) && (cnt_q == '0) && !write_q;
  assign ram_re_c    = rd_now_c || rd_late_c;
  assign ram_raddr_c = rd_late_c ? addr_q : idx_c;
  assign fwd_hit_c   = rd_now_c && wr_done_c && (addr_q == idx_c);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    write_d    = write_q;
    pend_wr_d  = pend_wr_q;
    fwd_d      = fwd_q;
    fwd_data_d = fwd_data_q;
    fwd_strb_d = fwd_strb_q;

    if (wr_done_c) pend_wr_d = 1'b0;

    case (state_q)
      ST_IDLE, ST_ERR2: begin
        if (HREADY) begin
          state_d = ST_IDLE;
          if (accept_c) begin
            addr_d  = idx_c;
            write_d = HWRITE;
            if (err_c) begin
              state_d = ST_ERR1;
            end else begin
              pend_wr_d = HWRITE;
              if (WAITS > 0) begin
                state_d = ST_WAIT;
                cnt_d   = WAIT_LOAD;
              end
            end
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - WAIT_CNT_W'(1);
      end
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase

    // Capture the completing write alongside every RAM read so a same-word hit can be merged.
    if (ram_re_c) begin
      fwd_d      = fwd_hit_c;
      fwd_data_d = HWDATA;
      fwd_strb_d = HWSTRB;
    end

    hready_d = (state_d == ST_IDLE) || (state_d == ST_ERR2);
    hresp_d  = ((state_d == ST_ERR1) || (state_d == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      write_q    <= 1'b0;
      pend_wr_q  <= 1'b0;
      fwd_q      <= 1'b0;
      fwd_data_q <= '0;
      fwd_strb_q <= '0;
      hready_q   <= 1'b1;
      hresp_q    <= HRESP_OKAY;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      write_q    <= write_d;
      pend_wr_q  <= pend_wr_d;
      fwd_q      <= fwd_d;
      fwd_data_q <= fwd_data_d;
      fwd_strb_q <= fwd_strb_d;
      hready_q   <= hready_d;
      hresp_q    <= hresp_d;
    end
  end

  ahb_ram_array #(
    .XLEN  (XLEN),
    .WORDS (WORDS)
  ) u_array (
    .clk_i   (clk),
    .rst_i   (reset),
    .we_i    (wr_done_c),
    .waddr_i (addr_q),
    .wdata_i (HWDATA),
    .wstrb_i (HWSTRB),
    .re_i    (ram_re_c),
    .raddr_i (ram_raddr_c),
    .rdata_o (ram_rdata_c)
  );

  always_comb begin
    hrdata_c = ram_rdata_c;
    if (fwd_q) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (fwd_strb_q[b]) hrdata_c[b*8 +: 8] = fwd_data_q[b*8 +: 8];
      end
    end
  end

  assign HRDATA    = hrdata_c;
  assign HREADYRam = hready_q;
  assign HRESPRam  = hresp_q;

endmodule

// File: tb/tb_ahb_ram_responder.sv
// Bench for ahb_ram_responder: four instances with different wait counts, a beat
// table driven as pipelined AHB transfers, and a scoreboard checked at completion.
module tb_ahb_ram_responder;
  import cvw::*;

  localparam int NI = 4;
  localparam int unsigned WAITS_TAB [NI] = '{0, 3, 1, 2};

  typedef struct {
    int          inst;
    logic [1:0]  trans;
    logic        wr;
    logic [33:0] addr;
    logic [2:0]  size;
    logic [63:0] wdata;
    logic [7:0]  strb;
    int          waits;
    logic        err;
    logic        chk;
    logic [63:0] rdata;
  } beat_t;

  typedef struct {
    int          id;
    int          waits;
    logic        err;
    logic        chk;
    logic [63:0] rdata;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_v [NI];
  logic        sel_b;
  logic [33:0] haddr;
  logic        hwrite;
  logic [2:0]  hsize, hburst;
  logic [1:0]  htrans;
  logic [63:0] hwdata;
  logic [7:0]  hwstrb;
  logic        rdy_w  [NI];
  logic        resp_w [NI];
  logic [63:0] rdata_w [NI];
  logic        hready;
  int          act = 0;

  logic [63:0] dp_wdata = '0;
  logic [7:0]  dp_strb  = '0;
  exp_t        sb[$];
  exp_t        mon_e;
  int          cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;
  beat_t       tab[$];

  assign hready = rdy_w[act];

  for (genvar k = 0; k < NI; k++) begin : g_dut
    ahb_ram_responder #(
      .PA_BITS (34),
      .XLEN    (64),
      .WORDS   (1024),
      .BASE    (64'h8000_0000),
      .WAITS   (WAITS_TAB[k])
    ) u_dut (
      .clk       (clk),
      .reset     (rst_v[k]),
      .HSELRam   (sel_b && (act == k)),
      .HADDR     (haddr),
      .HWRITE    (hwrite),
      .HSIZE     (hsize),
      .HBURST    (hburst),
      .HTRANS    (htrans),
      .HREADY    (hready),
      .HWDATA    (hwdata),
      .HWSTRB    (hwstrb),
      .HRDATA    (rdata_w[k]),
      .HREADYRam (rdy_w[k]),
      .HRESPRam  (resp_w[k])
    );
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  function automatic beat_t mk(input int inst, input logic [1:0] trans, input logic wr,
                               input logic [33:0] addr, input logic [2:0] size,
                               input logic [63:0] wdata, input logic [7:0] strb,
                               input int waits, input logic err, input logic chk_en,
                               input logic [63:0] rdata);
    beat_t b;
    b.inst = inst; b.trans = trans; b.wr = wr; b.addr = addr; b.size = size;
    b.wdata = wdata; b.strb = strb; b.waits = waits; b.err = err; b.chk = chk_en;
    b.rdata = rdata;
    return b;
  endfunction

  // Completion monitor: counts data-phase cycles and checks each beat when HREADYRam rises.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e = sb[0];
      cyc++;
      if (!rdy_w[act]) begin
        chk($sformatf("b%0d_stall_resp", mon_e.id), 64'(resp_w[act]), 64'(mon_e.err));
        if (cyc > 40) begin
          chk($sformatf("b%0d_timeout", mon_e.id), 64'(cyc), 64'(mon_e.waits + 1));
          void'(sb.pop_front());
          cyc = 0;
        end
      end else begin
        chk($sformatf("b%0d_waits", mon_e.id), 64'(cyc - 1), 64'(mon_e.waits));
        chk($sformatf("b%0d_resp", mon_e.id), 64'(resp_w[act]), 64'(mon_e.err));
        if (mon_e.chk) chk($sformatf("b%0d_rdata", mon_e.id), rdata_w[act], mon_e.rdata);
        void'(sb.pop_front());
        cyc = 0;
      end
    end
  end

  // Present one address phase until the bus accepts it, then queue its expectation.
  task automatic run_beat(input beat_t b, input int id);
    logic hr;
    int   guard;
    exp_t e;
    guard = 0;
    do begin
      @(negedge clk);
      sel_b  = 1'b1;
      htrans = b.trans;
      haddr  = b.addr;
      hwrite = b.wr;
      hsize  = b.size;
      hburst = (b.inst == 2) ? 3'b011 : 3'b000;
      hwdata = dp_wdata;
      hwstrb = dp_strb;
      hr     = hready;
      @(posedge clk);
      guard++;
    end while (!hr && guard < 64);
    if (!hr) begin
      chk($sformatf("b%0d_accept_timeout", id), 64'(0), 64'(1));
    end else if (b.trans != HTRANS_IDLE) begin
      e.id = id; e.waits = b.waits; e.err = b.err; e.chk = b.chk; e.rdata = b.rdata;
      sb.push_back(e);
      dp_wdata = b.wdata;
      dp_strb  = b.strb;
    end
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    do begin
      @(negedge clk);
      sel_b  = 1'b0;
      htrans = HTRANS_IDLE;
      hwdata = dp_wdata;
      hwstrb = dp_strb;
      @(posedge clk);
      guard++;
    end while (sb.size() > 0 && guard < 64);
    if (sb.size() > 0) begin
      chk("drain_timeout", 64'(sb.size()), 64'(0));
      sb.delete();
      cyc = 0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    sel_b = 1'b0; htrans = HTRANS_IDLE; haddr = '0; hwrite = 1'b0; hsize = 3'd3;
    hburst = 3'b000; hwdata = '0; hwstrb = '0;
    for (int k = 0; k < NI; k++) rst_v[k] = 1'b1;
    repeat (3) @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("rst%0d_ready", k), 64'(rdy_w[k]), 64'(1));
      chk($sformatf("rst%0d_resp", k), 64'(resp_w[k]), 64'(0));
      chk($sformatf("rst%0d_rdata", k), rdata_w[k], 64'h0);
    end
    for (int k = 0; k < NI; k++) rst_v[k] = 1'b0;

    // inst, trans, wr, addr, size, wdata, strb, waits, err, chk, rdata
    tab.push_back(mk(0, HTRANS_NONSEQ, 1, 34'h0_8000_0008, 3, 64'h1122334455667788, 8'hFF, 0, 0, 0, '0));
    tab.push_back(mk(0, HTRANS_NONSEQ, 0, 34'h0_8000_0008, 3, '0, 8'h00, 0, 0, 1, 64'h1122334455667788));
    tab.push_back(mk(0, HTRANS_NONSEQ, 1, 34'h0_8000_0000, 3, 64'h0, 8'hFF, 0, 0, 0, '0));
    tab.push_back(mk(0, HTRANS_NONSEQ, 1, 34'h0_8000_0000, 3, 64'hAAAAAAAAAAAAAAAA, 8'h0F, 0, 0, 0, '0));
    tab.push_back(mk(0, HTRANS_NONSEQ, 0, 34'h0_8000_0000, 3, '0, 8'h00, 0, 0, 1, 64'h00000000AAAAAAAA));
    tab.push_back(mk(0, HTRANS_NONSEQ, 0, 34'h0_8000_0008, 3, '0, 8'h00, 0, 0, 1, 64'h1122334455667788));
    tab.push_back(mk(1, HTRANS_NONSEQ, 1, 34'h0_8000_0010, 3, 64'h0123456789ABCDEF, 8'hFF, 3, 0, 0, '0));
    tab.push_back(mk(1, HTRANS_NONSEQ, 0, 34'h0_8000_0010, 3, '0, 8'h00, 3, 0, 1, 64'h0123456789ABCDEF));
    tab.push_back(mk(1, HTRANS_NONSEQ, 1, 34'h0_8000_0000, 3, 64'hCAFEF00DDEADBEEF, 8'hFF, 3, 0, 0, '0));
    tab.push_back(mk(1, HTRANS_NONSEQ, 1, 34'h0_8000_2000, 3, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 1, 1, 0, '0));
    tab.push_back(mk(1, HTRANS_NONSEQ, 0, 34'h0_8000_0003, 1, '0, 8'h00, 1, 1, 0, '0));
    tab.push_back(mk(1, HTRANS_NONSEQ, 0, 34'h0_8000_0000, 3, '0, 8'h00, 3, 0, 1, 64'hCAFEF00DDEADBEEF));
    tab.push_back(mk(1, HTRANS_NONSEQ, 0, 34'h0_8000_0000, 4, '0, 8'h00, 1, 1, 0, '0));
    tab.push_back(mk(2, HTRANS_NONSEQ, 1, 34'h0_8000_0020, 3, 64'h0F0E0D0C0B0A0908, 8'hFF, 1, 0, 0, '0));
    tab.push_back(mk(2, HTRANS_SEQ,    1, 34'h0_8000_0028, 3, 64'h1F1E1D1C1B1A1918, 8'hFF, 1, 0, 0, '0));
    tab.push_back(mk(2, HTRANS_SEQ,    1, 34'h0_8000_0030, 3, 64'h2F2E2D2C2B2A2928, 8'hFF, 1, 0, 0, '0));
    tab.push_back(mk(2, HTRANS_SEQ,    1, 34'h0_8000_0038, 3, 64'h3F3E3D3C3B3A3938, 8'hFF, 1, 0, 0, '0));
    tab.push_back(mk(2, HTRANS_NONSEQ, 0, 34'h0_8000_0020, 3, '0, 8'h00, 1, 0, 1, 64'h0F0E0D0C0B0A0908));
    tab.push_back(mk(2, HTRANS_SEQ,    0, 34'h0_8000_0028, 3, '0, 8'h00, 1, 0, 1, 64'h1F1E1D1C1B1A1918));
    tab.push_back(mk(2, HTRANS_BUSY,   0, 34'h0_8000_0030, 3, '0, 8'h00, 0, 0, 0, '0));
    tab.push_back(mk(2, HTRANS_SEQ,    0, 34'h0_8000_0030, 3, '0, 8'h00, 1, 0, 1, 64'h2F2E2D2C2B2A2928));
    tab.push_back(mk(2, HTRANS_SEQ,    0, 34'h0_8000_0038, 3, '0, 8'h00, 1, 0, 1, 64'h3F3E3D3C3B3A3938));
    tab.push_back(mk(2, HTRANS_NONSEQ, 1, 34'h0_8000_0021, 0, 64'h0000000000005A00, 8'h02, 1, 0, 0, '0));
    tab.push_back(mk(2, HTRANS_NONSEQ, 0, 34'h0_8000_0020, 3, '0, 8'h00, 1, 0, 1, 64'h0F0E0D0C0B0A5A08));
    tab.push_back(mk(3, HTRANS_NONSEQ, 1, 34'h0_8000_0010, 3, 64'h0A0A0A0A0A0A0A0A, 8'hFF, 2, 0, 0, '0));

    for (int i = 0; i < tab.size(); i++) begin
      if (tab[i].inst != act) begin
        drain();
        act = tab[i].inst;
      end
      run_beat(tab[i], i);
    end
    drain();

    // Reset lands in the WAIT state of a write: the write must be dropped.
    @(negedge clk);
    sel_b = 1'b1; htrans = HTRANS_NONSEQ; hwrite = 1'b1; haddr = 34'h0_8000_0010; hsize = 3'd3;
    @(posedge clk);
    @(negedge clk);
    sel_b = 1'b0; htrans = HTRANS_IDLE; hwdata = 64'h5555555555555555; hwstrb = 8'hFF;
    chk("rstw_in_wait_ready", 64'(rdy_w[3]), 64'(0));
    #2 rst_v[3] = 1'b1;
    #1;
    chk("rstw_ready", 64'(rdy_w[3]), 64'(1));
    chk("rstw_resp", 64'(resp_w[3]), 64'(0));
    chk("rstw_rdata", rdata_w[3], 64'h0);
    @(posedge clk);
    @(negedge clk);
    rst_v[3] = 1'b0;
    dp_wdata = 64'h5555555555555555;
    dp_strb  = 8'hFF;
    run_beat(mk(3, HTRANS_NONSEQ, 0, 34'h0_8000_0010, 3, '0, 8'h00, 2, 0, 1, 64'h0A0A0A0A0A0A0A0A), 100);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
